hazard_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 26 ++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_unit.sv | 115 +++++++++++
 tb/tb_hazard_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared opcode classes, FSM state encoding and register-use decode for the
// hazard unit.
package hazard_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_OPIMM);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, branch flush and slow-memory freeze control for the
// 5-stage pipeline, with saturating event statistics.
//
// state  | meaning
// RUN    | normal hazard evaluation; may freeze on a stalled memory access
// FREEZE | memory access outstanding; whole pipeline held, timeout counting
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_branch_taken,
  input  logic             dmem_ready,
  output logic             pipeline_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             mem_timeout
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(MEM_TIMEOUT);

  logic          ex_valid, ex_load, ex_acc;
  logic [4:0]    ex_rd;
  logic          mem_valid, mem_acc;
  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          mem_timeout_q;
  logic          load_use, freeze_cond, flush, stall;

  always_comb begin
    load_use = id_valid & ex_valid & ex_load & (ex_rd != 5'd0) &
               ((uses_rs1(id_opcode) & (ex_rd == id_rs1)) |
                (uses_rs2(id_opcode) & (ex_rd == id_rs2)));
    // With the shadows held during FREEZE this reduces to !dmem_ready there.
    freeze_cond = mem_valid & mem_acc & ~dmem_ready;
    flush       = ~freeze_cond & ex_branch_taken;
    stall       = ~freeze_cond & ~ex_branch_taken & load_use;
  end

  assign freeze         = freeze_cond;
  assign pipeline_stall = stall;
  assign if_id_flush    = flush;
  assign id_ex_flush    = flush;
  assign pc_write       = ~freeze_cond & ~stall;
  assign if_id_write    = ~freeze_cond & ~stall;
  assign mem_timeout    = mem_timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_load   <= 1'b0;
      ex_acc    <= 1'b0;
      ex_rd     <= 5'd0;
      mem_valid <= 1'b0;
      mem_acc   <= 1'b0;
    end else if (!freeze_cond) begin
      ex_valid  <= id_valid & ~stall & ~flush;
      ex_load   <= (id_opcode == OP_LOAD);
      ex_acc    <= (id_opcode == OP_LOAD) || (id_opcode == OP_STORE);
      ex_rd     <= id_rd;
      mem_valid <= ex_valid;
      mem_acc   <= ex_acc;
    end
  end

  always_comb begin
    state_d = freeze_cond ? FREEZE : RUN;
    tmo_d   = tmo_q;
    if (state_d == RUN) begin
      tmo_d = '0;
    end else if ((state_q == FREEZE) && (tmo_q != TMO_MAX)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      tmo_q         <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      mem_timeout_q <= mem_timeout_q | (tmo_d == TMO_MAX);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stall), .q(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush), .q(flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk(clk), .rst_n(rst_n), .inc(freeze_cond), .q(freeze_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a cycle-by-cycle vector table followed by
// timeout, counter saturation and reset-during-freeze sequences.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int CNT_W = 3;
  localparam int MEM_TIMEOUT = 4;
  localparam int NV = 17;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             ex_branch_taken;
  logic             dmem_ready;
  logic             pipeline_stall, pc_write, if_id_write;
  logic             if_id_flush, id_ex_flush, freeze;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
  logic             mem_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int e_stall_cnt = 0, e_flush_cnt = 0, e_freeze_cnt = 0;

  typedef struct {
    logic       vld;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       br, rdy;
    logic       e_stall, e_pcw, e_flush, e_frz;
  } vec_t;

  vec_t vecs[NV];

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
    .pipeline_stall(pipeline_stall), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .freeze(freeze),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt),
    .mem_timeout(mem_timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic br, input logic rdy);
    id_valid = vld; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    ex_branch_taken = br; dmem_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  initial begin
    // row: vld op rs1 rs2 rd br rdy | stall pcw flush frz
    vecs[0]  = '{1'b0, OP_NOP,    5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, OP_LOAD,   5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, OP_R,      5'd5, 5'd7, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, OP_R,      5'd5, 5'd7, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, OP_LOAD,   5'd2, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, OP_R,      5'd0, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, OP_LOAD,   5'd2, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, OP_OPIMM,  5'd1, 5'd3, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, OP_LOAD,   5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, OP_BRANCH, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, OP_STORE,  5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, OP_R,      5'd9, 5'd9, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, OP_NOP,    5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, OP_NOP,    5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, OP_NOP,    5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, OP_NOP,    5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, OP_NOP,    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pc_write", int'(pc_write), 1);
    chk("reset if_id_write", int'(if_id_write), 1);
    chk("reset stall", int'(pipeline_stall), 0);
    chk("reset freeze", int'(freeze), 0);
    chk("reset stall_cnt", int'(stall_cnt), 0);
    chk("reset mem_timeout", int'(mem_timeout), 0);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].vld, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].br, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d stall", i), int'(pipeline_stall), int'(vecs[i].e_stall));
      chk($sformatf("v%0d pc_write", i), int'(pc_write), int'(vecs[i].e_pcw));
      chk($sformatf("v%0d if_id_write", i), int'(if_id_write), int'(vecs[i].e_pcw));
      chk($sformatf("v%0d if_id_flush", i), int'(if_id_flush), int'(vecs[i].e_flush));
      chk($sformatf("v%0d id_ex_flush", i), int'(id_ex_flush), int'(vecs[i].e_flush));
      chk($sformatf("v%0d freeze", i), int'(freeze), int'(vecs[i].e_frz));
      e_stall_cnt  = sat7(e_stall_cnt + int'(vecs[i].e_stall));
      e_flush_cnt  = sat7(e_flush_cnt + int'(vecs[i].e_flush));
      e_freeze_cnt = sat7(e_freeze_cnt + int'(vecs[i].e_frz));
      next_cycle();
    end
    chk("table stall_cnt", int'(stall_cnt), e_stall_cnt);
    chk("table flush_cnt", int'(flush_cnt), e_flush_cnt);
    chk("table freeze_cnt", int'(freeze_cnt), e_freeze_cnt);
    chk("table mem_timeout", int'(mem_timeout), 0);

    // Timeout: store into MEM, then six cycles with memory not ready.
    drive(1'b1, OP_STORE, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    next_cycle();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("tmo freeze c%0d", k), int'(freeze), 1);
      if (k == 4) chk("tmo early mem_timeout", int'(mem_timeout), 0);
      if (k == 6) chk("tmo mem_timeout set", int'(mem_timeout), 1);
      next_cycle();
    end
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("tmo ready freeze", int'(freeze), 0);
    chk("tmo ready pc_write", int'(pc_write), 1);
    next_cycle();
    @(negedge clk);
    chk("tmo sticky", int'(mem_timeout), 1);
    chk("freeze_cnt saturates", int'(freeze_cnt), sat7(e_freeze_cnt + 6));
    next_cycle();

    // Reset asserted in the middle of a freeze.
    drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd4, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("pre-reset freeze", int'(freeze), 1);
      next_cycle();
    end
    rst_n = 1'b0;
    #1;
    chk("rst freeze", int'(freeze), 0);
    chk("rst pc_write", int'(pc_write), 1);
    chk("rst stall_cnt", int'(stall_cnt), 0);
    chk("rst flush_cnt", int'(flush_cnt), 0);
    chk("rst freeze_cnt", int'(freeze_cnt), 0);
    chk("rst mem_timeout", int'(mem_timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("post-reset freeze", int'(freeze), 0);
    chk("post-reset pc_write", int'(pc_write), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
